// File: rtl/fetch_queue_if.sv
// Fetch queue handshake bundle: imem request/response, execute redirect, and decode dequeue.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_valid;
    logic            deq_ready;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_instr;
    logic [XLEN-1:0] deq_pc_plus_4;
    logic [CW-1:0]   count;

    modport master (
        output imem_req_valid, imem_req_addr, deq_valid, deq_pc, deq_instr, deq_pc_plus_4, count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, deq_valid, deq_pc, deq_instr, deq_pc_plus_4, count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Credit-limited instruction fetch into an in-order queue; redirect flushes and drops in-flight responses.
// Response to deq_valid takes one cycle, or zero with FETCH_QUEUE_BYPASS_EN; requests stall once queued + outstanding reaches DEPTH.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;

    logic            req_fire;
    logic            rsp_live;
    logic            keep;
    logic            enq;
    logic            deq_q;
    logic [CW-1:0]   out_next;
    logic [XLEN-1:0] redir_pc;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic            bypass;
`endif

    always_comb begin
        req_fire = bus.imem_req_valid & bus.imem_req_ready;
        // A response with nothing outstanding is spurious and must not touch any state.
        rsp_live = bus.imem_rsp_valid & (outstanding != '0);
        keep     = rsp_live & (drop == '0) & !bus.redirect_valid;
        deq_q    = bus.deq_ready & (count != '0) & !bus.redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass   = keep & (count == '0);
        enq      = keep & !(bypass & bus.deq_ready);
`else
        enq      = keep;
`endif
        out_next = outstanding + CW'(req_fire) - CW'(rsp_live);
        redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end

    assign bus.imem_req_valid = !rst & !bus.redirect_valid &
                                (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bus.deq_valid      = !rst & ((count != '0) | bypass);
    assign bus.deq_pc         = (count == '0) ? rsp_pc : q_pc[head];
    assign bus.deq_instr      = (count == '0) ? bus.imem_rsp_data : q_instr[head];
`else
    assign bus.deq_valid      = !rst & (count != '0);
    assign bus.deq_pc         = q_pc[head];
    assign bus.deq_instr      = q_instr[head];
`endif
    assign bus.deq_pc_plus_4  = bus.deq_pc + STEP;
    assign bus.count          = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc    <= redir_pc;
            rsp_pc      <= redir_pc;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= out_next;
            drop        <= out_next;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            if (keep) rsp_pc <= rsp_pc + STEP;
            if (rsp_live && drop != '0) drop <= drop - CW'(1);
            if (enq) tail <= tail + PW'(1);
            if (deq_q) head <= head + PW'(1);
            outstanding <= out_next;
            count       <= count + CW'(enq) - CW'(deq_q);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail]    <= rsp_pc;
            q_instr[tail] <= bus.imem_rsp_data;
        end
    end
endmodule
